// File: rtl/ram_stream_reader_if.sv
// Handshake/bus bundle between the result-RAM drain engine and its environment.
// master = the drain engine, slave = the RAM port plus the stream sink plus the requester.
interface ram_stream_reader_if #(
    parameter int DATA  = 160,
    parameter int ADDR  = 9,
    parameter int OUT_W = 32
);
    logic             start;
    logic [ADDR-1:0]  base_addr;
    logic [ADDR:0]    count;
    logic             busy;
    logic             done;
    logic [ADDR-1:0]  ram_addr;
    logic             ram_wr;
    logic [DATA-1:0]  ram_rdata;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  start, base_addr, count, ram_rdata, out_ready,
        output busy, done, ram_addr, ram_wr, out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, count, ram_rdata, out_ready,
        input  busy, done, ram_addr, ram_wr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Drains COUNT consecutive entries from a read-only RAM port and serializes each
// entry, most-significant word first, onto a valid/ready stream.
module ram_stream_reader #(
    parameter int DATA  = 160,
    parameter int ADDR  = 9,
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    ram_stream_reader_if.master bus
);
    localparam int WORDS = DATA / OUT_W;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_SEND,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [ADDR-1:0]  ram_addr_q;
    logic [ADDR-1:0]  ram_addr_d;
    logic [ADDR:0]    left_q;
    logic [ADDR:0]    left_d;
    logic [DATA-1:0]  shreg_q;
    logic [WCW-1:0]   word_cnt_q;
    logic [WCW-1:0]   word_cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             last_q;
    logic             handshake;
    logic             word_is_last;

    assign handshake    = valid_q && bus.out_ready;
    assign ram_addr_d   = ram_addr_q + ADDR'(1);
    assign left_d       = left_q - (ADDR + 1)'(1);
    assign word_cnt_d   = word_cnt_q + WCW'(1);
    assign word_is_last = (word_cnt_q == WCW'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ram_addr_q <= '0;
            left_q     <= '0;
            shreg_q    <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        left_q <= bus.count;
                        // done is raised on entry to FIN so it is high while FIN is current
                        if (bus.count == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_FIN;
                        end else begin
                            ram_addr_q <= bus.base_addr;
                            busy_q     <= 1'b1;
                            state_q    <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    shreg_q    <= bus.ram_rdata;
                    word_cnt_q <= '0;
                    valid_q    <= 1'b1;
                    last_q     <= (WORDS == 1);
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (handshake) begin
                        shreg_q    <= shreg_q << OUT_W;
                        word_cnt_q <= word_cnt_d;
                        last_q     <= (word_cnt_d == WCW'(WORDS - 1));
                        if (word_is_last) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            left_q  <= left_d;
                            if (left_d == '0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_FIN;
                            end else begin
                                ram_addr_q <= ram_addr_d;
                                state_q    <= S_ADDR;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wr    = 1'b0;
    assign bus.out_data  = shreg_q[DATA-1 -: OUT_W];
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
endmodule
